// File: rtl/p_ssync_req_arb.sv
// p_ssync_req_arb: synchronizes per-channel 4-phase reqs and round-robin arbitrates them onto one valid/ready word.
// Optional sticky protocol-error output err_proto when P_SSYNC_REQ_ARB_ERR_EN is defined.
module p_ssync_req_arb #(
  parameter int NCH = 4,
  parameter int DW = 8,
  parameter int SYNC_STAGES = 2,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              clr_,
  input  logic [NCH-1:0]    req_async,
  input  logic [NCH*DW-1:0] data_async,
  output logic [NCH-1:0]    ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [CW-1:0]     out_ch
`ifdef P_SSYNC_REQ_ARB_ERR_EN
  ,
  output logic              err_proto
`endif
);
  typedef enum logic [1:0] {IDLE, PEND, BUSY, ACKH} st_t;
  st_t st [NCH];
  logic [SYNC_STAGES-1:0] sync [NCH];
  logic [NCH-1:0] req_s, pend;
  logic [CW-1:0] rr, gnt_idx;
  logic gnt_v, take;
  int j;
`ifdef P_SSYNC_REQ_ARB_ERR_EN
  logic err_ev;
`endif
  assign take = out_valid && out_ready;
  always_comb begin
    req_s = '0;
    pend = '0;
    gnt_v = 1'b0;
    gnt_idx = '0;
    j = 0;
`ifdef P_SSYNC_REQ_ARB_ERR_EN
    err_ev = 1'b0;
`endif
    for (int k = 0; k < NCH; k++) begin
      req_s[k] = sync[k][SYNC_STAGES-1];
      pend[k] = st[k] == PEND && req_s[k];
`ifdef P_SSYNC_REQ_ARB_ERR_EN
      err_ev = err_ev || (!req_s[k] && (st[k] == PEND || (st[k] == BUSY && take)));
`endif
    end
    // descending scan so the channel closest to rr wins
    for (int i = NCH - 1; i >= 0; i--) begin
      j = int'(rr) + i;
      j = (j >= NCH) ? j - NCH : j;
      if (pend[j] && (!out_valid || out_ready)) begin
        gnt_v = 1'b1;
        gnt_idx = CW'(j);
      end
    end
  end
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      for (int k = 0; k < NCH; k++) begin
        st[k] <= IDLE;
        sync[k] <= '0;
      end
      ack <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      rr <= '0;
`ifdef P_SSYNC_REQ_ARB_ERR_EN
      err_proto <= 1'b0;
`endif
    end else begin
      if (take) out_valid <= 1'b0;
      if (gnt_v) begin
        out_valid <= 1'b1;
        out_data <= data_async[int'(gnt_idx)*DW +: DW];
        out_ch <= gnt_idx;
        rr <= (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
      end
`ifdef P_SSYNC_REQ_ARB_ERR_EN
      if (err_ev) err_proto <= 1'b1;
`endif
      for (int k = 0; k < NCH; k++) begin
        sync[k] <= {sync[k][SYNC_STAGES-2:0], req_async[k]};
        case (st[k])
          IDLE: if (req_s[k]) st[k] <= PEND;
          PEND: st[k] <= (gnt_v && int'(gnt_idx) == k) ? BUSY : (req_s[k] ? PEND : IDLE);
          BUSY: if (take) begin
            st[k] <= ACKH;
            ack[k] <= 1'b1;
          end
          default: if (!req_s[k]) begin
            st[k] <= IDLE;
            ack[k] <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
